// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: memory-side stage behind the LC-3 datapath.
// Runs a four-phase handshaked access for each request, either to the
// off-chip 16-bit SRAM or to the switch/hex I/O word at IO_ADDR. Every
// output is a flop.
//
// Ports:
//   Clk, Reset              clock, asynchronous active-low reset
//   Mem_Req, Mem_WE         request and direction (1 = write) from the control FSM
//   MAR, MDR                address and write data, captured when the request is accepted
//   Switches                board switch word, returned on I/O reads
//   Data_from_SRAM          SRAM DQ read value
//   MDR_In                  read data to the datapath MDR mux
//   Mem_Ready               transaction complete, held until Mem_Req drops
//   SRAM_ADDR, SRAM_*_N     SRAM address and active-low strobes
//   Data_to_SRAM            SRAM write data
//   SRAM_DQ_OE              1 = top level drives DQ with Data_to_SRAM
//   HEX_Data                last word written to IO_ADDR
module lc3_mem_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Mem_Req,
    input  logic        Mem_WE,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    input  logic [15:0] Switches,
    input  logic [15:0] Data_from_SRAM,
    output logic [15:0] MDR_In,
    output logic        Mem_Ready,
    output logic [19:0] SRAM_ADDR,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic [15:0] Data_to_SRAM,
    output logic        SRAM_DQ_OE,
    output logic [15:0] HEX_Data
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 20;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   mdr_in_q, mdr_in_d;
    logic [DATA_W-1:0]   hex_q, hex_d;

    logic                mem_ready_q, mem_ready_d;
    logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
    logic                ce_n_q, ce_n_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;
    logic                dq_oe_q, dq_oe_d;
    logic                sram_active;

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, request capture and read/I-O data updates
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        we_d     = we_q;
        mdr_in_d = mdr_in_q;
        hex_d    = hex_q;
        unique case (state_q)
            S_IDLE: begin
                if (Mem_Req) begin
                    addr_d = MAR;
                    data_d = MDR;
                    we_d   = Mem_WE;
                    // I/O word is serviced on the capture edge; it never reaches SRAM
                    if (MAR == IO_ADDR) begin
                        state_d = S_DONE;
                        if (Mem_WE) begin
                            hex_d = MDR;
                        end else begin
                            mdr_in_d = Switches;
                        end
                    end else begin
                        state_d = S_SETUP;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    if (!we_q) begin
                        mdr_in_d = Data_from_SRAM;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                if (!Mem_Req) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobe values for the upcoming state, so the flopped strobes track state_q exactly
    always_comb begin
        sram_active = (state_d == S_SETUP) || (state_d == S_ACCESS);
        mem_ready_d = (state_d == S_DONE);
        ce_n_d      = !sram_active;
        oe_n_d      = !(sram_active && !we_d);
        // WE held off during SETUP to give address setup ahead of the write strobe
        we_n_d      = !((state_d == S_ACCESS) && we_d);
        dq_oe_d     = sram_active && we_d;
        sram_addr_d = sram_active ? {4'b0, addr_d} : '0;
    end

    // Datapath and output registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            we_q        <= 1'b0;
            mdr_in_q    <= '0;
            hex_q       <= '0;
            mem_ready_q <= 1'b0;
            sram_addr_q <= '0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            we_q        <= we_d;
            mdr_in_q    <= mdr_in_d;
            hex_q       <= hex_d;
            mem_ready_q <= mem_ready_d;
            sram_addr_q <= sram_addr_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            dq_oe_q     <= dq_oe_d;
        end
    end

    assign MDR_In       = mdr_in_q;
    assign Mem_Ready    = mem_ready_q;
    assign SRAM_ADDR    = sram_addr_q;
    assign SRAM_CE_N    = ce_n_q;
    assign SRAM_OE_N    = oe_n_q;
    assign SRAM_WE_N    = we_n_q;
    assign SRAM_UB_N    = ce_n_q;
    assign SRAM_LB_N    = ce_n_q;
    assign Data_to_SRAM = data_q;
    assign SRAM_DQ_OE   = dq_oe_q;
    assign HEX_Data     = hex_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed bench for lc3_mem_ctrl: expected read/hex values and latencies are
// queued when a request is driven and checked when Mem_Ready rises.
module tb_lc3_mem_ctrl;

    localparam int unsigned WAIT_CYCLES = 2;
    localparam int unsigned TIMEOUT     = 50;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mar;
    logic [15:0] mdr;
    logic [15:0] switches;
    logic [15:0] sram_rd;
    logic [15:0] mdr_in;
    logic        mem_ready;
    logic [19:0] sram_addr;
    logic        ce_n, oe_n, we_n, ub_n, lb_n;
    logic [15:0] data_to_sram;
    logic        dq_oe;
    logic [15:0] hex_data;

    lc3_mem_ctrl #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .IO_ADDR     (16'hFFFF)
    ) dut (
        .Clk            (clk),
        .Reset          (rst_n),
        .Mem_Req        (mem_req),
        .Mem_WE         (mem_we),
        .MAR            (mar),
        .MDR            (mdr),
        .Switches       (switches),
        .Data_from_SRAM (sram_rd),
        .MDR_In         (mdr_in),
        .Mem_Ready      (mem_ready),
        .SRAM_ADDR      (sram_addr),
        .SRAM_CE_N      (ce_n),
        .SRAM_OE_N      (oe_n),
        .SRAM_WE_N      (we_n),
        .SRAM_UB_N      (ub_n),
        .SRAM_LB_N      (lb_n),
        .Data_to_SRAM   (data_to_sram),
        .SRAM_DQ_OE     (dq_oe),
        .HEX_Data       (hex_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] mdr_in;
        logic [15:0] hex;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] model_mdr = 16'h0;
    logic [15:0] model_hex = 16'h0;

    // Strobe activity gathered while a transaction is in flight
    int ce_cnt, oe_cnt, we_cnt, dq_cnt, strb_bad, addr_bad, data_bad, we_setup;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sample(input logic [19:0] exp_addr, input logic [15:0] exp_data, input bit first);
        if (!ce_n) begin
            ce_cnt++;
            if (sram_addr !== exp_addr) addr_bad++;
        end
        if (ub_n !== ce_n || lb_n !== ce_n) strb_bad++;
        if (!oe_n) oe_cnt++;
        if (!we_n) begin
            we_cnt++;
            if (first) we_setup++;
        end
        if (dq_oe) begin
            dq_cnt++;
            if (data_to_sram !== exp_data) data_bad++;
        end
    endtask

    // One handshaked transaction. hold = cycles Mem_Req stays high after Mem_Ready
    // (0 = drop right after the capture edge); scramble perturbs MAR/MDR/WE after capture.
    task automatic run_txn(input string tag, input logic we, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [15:0] rd,
                           input int hold, input bit scramble);
        exp_t e, got;
        bit   is_io;
        int   n;
        int   exp_act;
        is_io = (addr == 16'hFFFF);
        if (is_io && we)       model_hex = wdata;
        else if (!we && is_io) model_mdr = switches;
        else if (!we)          model_mdr = rd;
        e.mdr_in = model_mdr;
        e.hex    = model_hex;
        e.lat    = is_io ? 0 : int'(WAIT_CYCLES) + 1;
        sb.push_back(e);

        ce_cnt = 0; oe_cnt = 0; we_cnt = 0; dq_cnt = 0;
        strb_bad = 0; addr_bad = 0; data_bad = 0; we_setup = 0;

        @(negedge clk);
        mem_req = 1'b1;
        mem_we  = we;
        mar     = addr;
        mdr     = wdata;
        sram_rd = rd;
        @(posedge clk);
        @(negedge clk);
        if (hold == 0) mem_req = 1'b0;
        if (scramble) begin
            mar    = 16'h7777;
            mdr    = 16'h5555;
            mem_we = ~we;
        end
        n = 0;
        sample({4'h0, addr}, wdata, 1'b1);
        while (!mem_ready && n < int'(TIMEOUT)) begin
            @(negedge clk);
            n++;
            sample({4'h0, addr}, wdata, 1'b0);
        end

        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            check({tag, ".latency"}, 32'(n), 32'(got.lat));
            check({tag, ".mdr_in"}, 32'(mdr_in), 32'(got.mdr_in));
            check({tag, ".hex"}, 32'(hex_data), 32'(got.hex));
        end
        exp_act = is_io ? 0 : int'(WAIT_CYCLES) + 1;
        check({tag, ".ce_cycles"}, 32'(ce_cnt), 32'(exp_act));
        check({tag, ".oe_cycles"}, 32'(oe_cnt), (we || is_io) ? 32'd0 : 32'(exp_act));
        check({tag, ".we_cycles"}, 32'(we_cnt), (we && !is_io) ? 32'(WAIT_CYCLES) : 32'd0);
        check({tag, ".dq_oe_cycles"}, 32'(dq_cnt), (we && !is_io) ? 32'(exp_act) : 32'd0);
        check({tag, ".we_in_setup"}, 32'(we_setup), 32'd0);
        check({tag, ".addr_bad"}, 32'(addr_bad), 32'd0);
        check({tag, ".data_bad"}, 32'(data_bad), 32'd0);
        check({tag, ".ub_lb_bad"}, 32'(strb_bad), 32'd0);

        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check({tag, ".ready_held"}, 32'(mem_ready), 32'd1);
                check({tag, ".no_retrigger"}, 32'(ce_n), 32'd1);
            end
            mem_req = 1'b0;
        end
        @(negedge clk);
        check({tag, ".ready_fall"}, 32'(mem_ready), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mar      = 16'h0;
        mdr      = 16'h0;
        switches = 16'h0;
        sram_rd  = 16'h0;
        repeat (2) @(negedge clk);

        check("rst.mem_ready", 32'(mem_ready), 32'd0);
        check("rst.mdr_in", 32'(mdr_in), 32'd0);
        check("rst.hex", 32'(hex_data), 32'd0);
        check("rst.strobes", 32'({ce_n, oe_n, we_n, ub_n, lb_n}), 32'h1F);
        check("rst.dq_oe", 32'(dq_oe), 32'd0);
        check("rst.addr", 32'(sram_addr), 32'd0);
        check("rst.wdata", 32'(data_to_sram), 32'd0);
        rst_n = 1'b1;

        run_txn("sram_rd", 1'b0, 16'h0010, 16'h0000, 16'h1234, 2, 1'b0);
        run_txn("sram_wr", 1'b1, 16'h3000, 16'hBEEF, 16'hDEAD, 0, 1'b0);
        switches = 16'h00A5;
        run_txn("io_rd", 1'b0, 16'hFFFF, 16'h0000, 16'hDEAD, 0, 1'b0);
        run_txn("io_wr", 1'b1, 16'hFFFF, 16'h0042, 16'hDEAD, 1, 1'b0);
        run_txn("hold10", 1'b0, 16'h0020, 16'h0000, 16'hABCD, 10, 1'b0);
        run_txn("isolate", 1'b0, 16'h0010, 16'h0000, 16'h5A5A, 1, 1'b1);

        // Reset in the middle of an SRAM write
        @(negedge clk);
        mem_req = 1'b1;
        mem_we  = 1'b1;
        mar     = 16'h0100;
        mdr     = 16'h1111;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        check("midrst.in_access", 32'(we_n), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst.we_n", 32'(we_n), 32'd1);
        check("midrst.ce_n", 32'(ce_n), 32'd1);
        check("midrst.dq_oe", 32'(dq_oe), 32'd0);
        check("midrst.addr", 32'(sram_addr), 32'd0);
        check("midrst.mem_ready", 32'(mem_ready), 32'd0);
        check("midrst.mdr_in", 32'(mdr_in), 32'd0);
        check("midrst.hex", 32'(hex_data), 32'd0);
        mem_req   = 1'b0;
        model_mdr = 16'h0;
        model_hex = 16'h0;
        @(negedge clk);
        check("midrst.held_idle", 32'(ce_n), 32'd1);
        rst_n = 1'b1;

        run_txn("post_rst", 1'b0, 16'h0200, 16'h0000, 16'h0F0F, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
